demux_stripe_ctrl: RTL

DEMUX_STRIPE_CTRL -- requirements
Module: demux_stripe_ctrl

---
 rtl/demux_stripe_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/demux_stripe_ctrl.sv
// demux_stripe_ctrl
// Distributes an incoming byte stream round-robin across 1, 2 or 4 output
// lanes. Each lane has its own registered data/valid pair. A per-lane
// backpressure vector stalls the stream when the target lane is full.
// Lane-count changes take effect only at a stripe boundary, so a stripe
// that has already started is never split across two configurations.

module demux_stripe_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        lane_mode,
    input  logic [3:0]        lane_full,
    output logic              ready_out,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              valid_out2,
    output logic              valid_out3,
    output logic [1:0]        lane_ptr,
    output logic              stripe_done,
    output logic [7:0]        byte_count,
    output logic              stall,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    // Index of the last active lane for a stored lane mode.
    // Mode 3 is reserved and behaves like 4 lanes.
    function automatic logic [1:0] last_lane(input logic [1:0] mode);
        logic [1:0] idx;
        case (mode)
            2'd0:    idx = 2'd0;
            2'd1:    idx = 2'd1;
            2'd2:    idx = 2'd3;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Registered state
    state_t            state_q;
    state_t            state_d;
    logic [1:0]        cfg_q;
    logic [1:0]        cfg_d;
    logic [1:0]        lane_ptr_q;
    logic [1:0]        lane_ptr_d;
    logic [DATA_W-1:0] data_q [4];
    logic [DATA_W-1:0] data_d [4];
    logic [3:0]        valid_q;
    logic [3:0]        valid_d;
    logic              stripe_done_q;
    logic              stripe_done_d;
    logic [7:0]        byte_count_q;
    logic [7:0]        byte_count_d;
    logic              stall_q;
    logic              stall_d;
    logic              cfg_err_q;
    logic              cfg_err_d;

    // Combinational handshake terms
    logic              lane_blocked_s;
    logic              ready_s;
    logic              accept_s;
    logic              wrap_s;

    // Handshake: the lane under the pointer decides whether the byte can go.
    // The pointer never reaches a lane beyond the active count, so full bits
    // of inactive lanes are never looked at.
    always_comb begin
        lane_blocked_s = lane_full[lane_ptr_q];
        ready_s        = ~reset & ~lane_blocked_s;
        accept_s       = valid_in & ready_s;
        wrap_s         = (lane_ptr_q == last_lane(cfg_q));
    end

    // Next-state computation for pointer, lane registers, counters and FSM
    always_comb begin
        lane_ptr_d    = lane_ptr_q;
        cfg_d         = cfg_q;
        valid_d       = 4'b0000;
        stripe_done_d = 1'b0;
        byte_count_d  = byte_count_q;
        state_d       = ST_IDLE;
        stall_d       = 1'b0;
        cfg_err_d     = cfg_err_q;
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
        end

        // Lane write and pointer advance on accept
        if (accept_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_ptr_q == 2'(i)) begin
                    data_d[i]  = data_in;
                    valid_d[i] = 1'b1;
                end else begin
                    data_d[i]  = data_q[i];
                    valid_d[i] = 1'b0;
                end
            end
            if (wrap_s) begin
                lane_ptr_d = 2'd0;
            end else begin
                lane_ptr_d = lane_ptr_q + 2'd1;
            end
            stripe_done_d = wrap_s;
            byte_count_d  = byte_count_q + 8'd1;
        end else begin
            lane_ptr_d    = lane_ptr_q;
            stripe_done_d = 1'b0;
            byte_count_d  = byte_count_q;
        end

        // A new lane count is only picked up at a stripe boundary
        if (lane_ptr_d == 2'd0) begin
            cfg_d = lane_mode;
        end else begin
            cfg_d = cfg_q;
        end

        // Reserved mode seen at any edge latches the error flag
        if (lane_mode == 2'd3) begin
            cfg_err_d = 1'b1;
        end else begin
            cfg_err_d = cfg_err_q;
        end

        // FSM: stall has priority, then active on accept, else idle
        if (valid_in && lane_blocked_s) begin
            state_d = ST_STALL;
        end else if (accept_s) begin
            state_d = ST_ACTIVE;
        end else begin
            state_d = ST_IDLE;
        end

        case (state_d)
            ST_STALL:  stall_d = 1'b1;
            ST_ACTIVE: stall_d = 1'b0;
            ST_IDLE:   stall_d = 1'b0;
            default:   stall_d = 1'b0;
        endcase
    end

    // State registers with synchronous reset; reset drops any partial stripe
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cfg_q         <= 2'd2;
            lane_ptr_q    <= 2'd0;
            valid_q       <= 4'b0000;
            stripe_done_q <= 1'b0;
            byte_count_q  <= 8'd0;
            stall_q       <= 1'b0;
            cfg_err_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            lane_ptr_q    <= lane_ptr_d;
            valid_q       <= valid_d;
            stripe_done_q <= stripe_done_d;
            byte_count_q  <= byte_count_d;
            stall_q       <= stall_d;
            cfg_err_q     <= cfg_err_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Output mapping from registers (ready_out is the only combinational output)
    always_comb begin
        ready_out   = ready_s;
        data_out0   = data_q[0];
        data_out1   = data_q[1];
        data_out2   = data_q[2];
        data_out3   = data_q[3];
        valid_out0  = valid_q[0];
        valid_out1  = valid_q[1];
        valid_out2  = valid_q[2];
        valid_out3  = valid_q[3];
        lane_ptr    = lane_ptr_q;
        stripe_done = stripe_done_q;
        byte_count  = byte_count_q;
        stall       = stall_q;
        cfg_err     = cfg_err_q;
    end

endmodule
